bubble_motion: RTL and testbench

//  Sequential position generator for one air bubble. Feeds bub1X/bub1Y to the

---
 rtl/sub_pkg.sv | 13 +
 rtl/rise_edge_det.sv | 22 ++
 rtl/bubble_motion.sv | 151 +++++++++++++++
 tb/tb_bubble_motion.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared sprite-mover definitions: FSM state encoding and the off-screen
// PARK coordinate used whenever a sprite is not on screen.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RISING = 2'd1,
      POP    = 2'd2
   } state_t;

   localparam logic signed [11:0] PARK = -12'sd64;

endpackage

// File: rtl/rise_edge_det.sv
// Registered rising-edge detector: pulse is high for one clk, one clk after
// d goes 0->1.  Ports: clk, rst (async high), d (level in), pulse (out).
module rise_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         prev  <= d;
         pulse <= d & ~prev;
      end
   end

endmodule

// File: rtl/bubble_motion.sv
// Air-bubble position generator: spawns at the sub on a launch edge, rises
// per frame, pops at the top, parks off-screen.  Optional BUBBLE_WOBBLE_EN
// adds a triangle X wobble.  Ports: clk, rst, vsync, launch, subX, subY in;
// bub1X, bub1Y (registered centre), bub_active, bub_pop out.
module bubble_motion
   import sub_pkg::*;
#(
   parameter logic signed [11:0] SPAWN_DX   = 12'sd16,
   parameter logic signed [11:0] SPAWN_DY   = -12'sd8,
   parameter logic signed [11:0] RISE_STEP  = 12'sd2,
   parameter int                 RISE_DIV   = 2,
   parameter logic signed [11:0] TOP_LIMIT  = 12'sd8,
   parameter int                 POP_FRAMES = 8,
   parameter logic signed [11:0] WOBBLE_AMP = 12'sd3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vsync,
   input  logic               launch,
   input  logic signed [11:0] subX,
   input  logic signed [11:0] subY,
   output logic signed [11:0] bub1X,
   output logic signed [11:0] bub1Y,
   output logic               bub_active,
   output logic               bub_pop
);

   logic tick;
   logic fire;

   rise_edge_det u_vs (.clk(clk), .rst(rst), .d(vsync),  .pulse(tick));
   rise_edge_det u_ln (.clk(clk), .rst(rst), .d(launch), .pulse(fire));

   state_t            state, state_n;
   logic signed [11:0] x_n, y_n, y_dec;
   logic [7:0]        div, div_n;
   logic [7:0]        pcnt, pcnt_n;

`ifdef BUBBLE_WOBBLE_EN
   logic signed [11:0] sx, sx_n;
   logic signed [11:0] wob, wob_n;
   logic               up, up_n;
`endif

   assign y_dec = bub1Y - RISE_STEP;

   always_comb begin
      state_n = state;
      x_n     = bub1X;
      y_n     = bub1Y;
      div_n   = div;
      pcnt_n  = pcnt;
`ifdef BUBBLE_WOBBLE_EN
      sx_n    = sx;
      wob_n   = wob;
      up_n    = up;
`endif
      unique case (state)
         IDLE: begin
            // a coincident frame tick is dropped: spawn wins
            if (fire) begin
               state_n = RISING;
               x_n     = subX + SPAWN_DX;
               y_n     = subY + SPAWN_DY;
               div_n   = '0;
               pcnt_n  = '0;
`ifdef BUBBLE_WOBBLE_EN
               sx_n    = subX + SPAWN_DX;
               wob_n   = '0;
               up_n    = 1'b1;
`endif
            end
         end
         RISING: begin
            if (tick) begin
               if (div == 8'(RISE_DIV - 1)) begin
                  div_n = '0;
                  y_n   = y_dec;
`ifdef BUBBLE_WOBBLE_EN
                  // triangle: reverse direction at +/-AMP
                  if (up && wob == WOBBLE_AMP) begin
                     up_n  = 1'b0;
                     wob_n = wob - 12'sd1;
                  end else if (!up && wob == -WOBBLE_AMP) begin
                     up_n  = 1'b1;
                     wob_n = wob + 12'sd1;
                  end else begin
                     wob_n = up ? wob + 12'sd1 : wob - 12'sd1;
                  end
                  x_n = sx + wob_n;
`endif
                  if (y_dec <= TOP_LIMIT) begin
                     y_n     = TOP_LIMIT;
                     state_n = POP;
                     pcnt_n  = '0;
                  end
               end else begin
                  div_n = div + 8'd1;
               end
            end
         end
         POP: begin
            if (tick) begin
               if (pcnt == 8'(POP_FRAMES - 1)) begin
                  state_n = IDLE;
                  x_n     = PARK;
                  y_n     = PARK;
                  pcnt_n  = '0;
               end else begin
                  pcnt_n = pcnt + 8'd1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            x_n     = PARK;
            y_n     = PARK;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         bub1X <= PARK;
         bub1Y <= PARK;
         div   <= '0;
         pcnt  <= '0;
`ifdef BUBBLE_WOBBLE_EN
         sx    <= PARK;
         wob   <= '0;
         up    <= 1'b1;
`endif
      end else begin
         state <= state_n;
         bub1X <= x_n;
         bub1Y <= y_n;
         div   <= div_n;
         pcnt  <= pcnt_n;
`ifdef BUBBLE_WOBBLE_EN
         sx    <= sx_n;
         wob   <= wob_n;
         up    <= up_n;
`endif
      end
   end

   assign bub_active = (state == RISING) || (state == POP);
   assign bub_pop    = (state == POP);

endmodule

// File: tb/tb_bubble_motion.sv
// Directed self-checking bench for bubble_motion.
module tb_bubble_motion;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               vsync = 1'b0;
   logic               launch = 1'b0;
   logic signed [11:0] subX = '0;
   logic signed [11:0] subY = '0;
   logic signed [11:0] bub1X, bub1Y;
   logic               bub_active, bub_pop;

   int checks = 0;
   int failures = 0;

   bubble_motion dut (
      .clk(clk), .rst(rst), .vsync(vsync), .launch(launch),
      .subX(subX), .subY(subY), .bub1X(bub1X), .bub1Y(bub1Y),
      .bub_active(bub_active), .bub_pop(bub_pop)
   );

   always #5 clk = ~clk;

   // one frame tick; returns at a negedge after the FSM has acted
   task automatic frame();
      @(negedge clk) vsync = 1'b1;
      @(negedge clk) vsync = 1'b0;
      @(negedge clk);
   endtask

   task automatic press();
      @(negedge clk) launch = 1'b1;
      @(negedge clk) launch = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bub1X !== -12'sd64 || bub1Y !== -12'sd64 ||
          bub_active !== 1'b0 || bub_pop !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got %0d,%0d a=%b p=%b want -64,-64 a=0 p=0",
                  bub1X, bub1Y, bub_active, bub_pop);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_spawn();
      subX = 12'sd100;
      subY = 12'sd300;
      @(negedge clk) launch = 1'b1;
      @(negedge clk) launch = 1'b0;
      checks++;
      if (bub1Y !== -12'sd64 || bub_active !== 1'b0) begin
         failures++;
         $display("FAIL spawn_latency got Y=%0d a=%b want -64 a=0",
                  bub1Y, bub_active);
      end
      @(negedge clk);
      checks++;
      if (bub1X !== 12'sd116 || bub1Y !== 12'sd292 || bub_active !== 1'b1) begin
         failures++;
         $display("FAIL spawn_pos got %0d,%0d a=%b want 116,292 a=1",
                  bub1X, bub1Y, bub_active);
      end
   endtask

   task automatic test_rise();
      frame();
      checks++;
      if (bub1Y !== 12'sd292) begin
         failures++;
         $display("FAIL rise_div1 got %0d want 292", bub1Y);
      end
      frame();
      checks++;
      if (bub1Y !== 12'sd290) begin
         failures++;
         $display("FAIL rise_step1 got %0d want 290", bub1Y);
      end
      subX = 12'sd500;
      subY = 12'sd500;
      press();
      checks++;
      if (bub1X !== 12'sd116 || bub1Y !== 12'sd290) begin
         failures++;
         $display("FAIL launch_ignored got %0d,%0d want 116,290",
                  bub1X, bub1Y);
      end
      for (int i = 0; i < 8; i++) begin
         frame();
         if (i == 3) press();
      end
      checks++;
      if (bub1X !== 12'sd116 || bub1Y !== 12'sd282 || bub_pop !== 1'b0) begin
         failures++;
         $display("FAIL rise_10ticks got %0d,%0d p=%b want 116,282 p=0",
                  bub1X, bub1Y, bub_pop);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bub1X !== -12'sd64 || bub1Y !== -12'sd64 || bub_active !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got %0d,%0d a=%b want -64,-64 a=0",
                  bub1X, bub1Y, bub_active);
      end
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_pop();
      subX = 12'sd50;
      subY = 12'sd20;
      press();
      checks++;
      if (bub1Y !== 12'sd12 || bub_active !== 1'b1 || bub_pop !== 1'b0) begin
         failures++;
         $display("FAIL pop_spawn got Y=%0d a=%b p=%b want 12 a=1 p=0",
                  bub1Y, bub_active, bub_pop);
      end
      frame();
      frame();
      checks++;
      if (bub1Y !== 12'sd10 || bub_pop !== 1'b0) begin
         failures++;
         $display("FAIL pop_y10 got Y=%0d p=%b want 10 p=0", bub1Y, bub_pop);
      end
      frame();
      frame();
      checks++;
      if (bub1Y !== 12'sd8 || bub_pop !== 1'b1 || bub_active !== 1'b1) begin
         failures++;
         $display("FAIL pop_enter got Y=%0d a=%b p=%b want 8 a=1 p=1",
                  bub1Y, bub_active, bub_pop);
      end
      press();
      for (int i = 0; i < 7; i++) frame();
      checks++;
      if (bub1X !== 12'sd66 || bub1Y !== 12'sd8 || bub_pop !== 1'b1) begin
         failures++;
         $display("FAIL pop_hold7 got %0d,%0d p=%b want 66,8 p=1",
                  bub1X, bub1Y, bub_pop);
      end
      frame();
      checks++;
      if (bub1X !== -12'sd64 || bub1Y !== -12'sd64 ||
          bub_active !== 1'b0 || bub_pop !== 1'b0) begin
         failures++;
         $display("FAIL pop_park got %0d,%0d a=%b p=%b want -64,-64 a=0 p=0",
                  bub1X, bub1Y, bub_active, bub_pop);
      end
   endtask

   task automatic test_low_spawn();
      subX = 12'sd10;
      subY = 12'sd10;
      press();
      checks++;
      if (bub1Y !== 12'sd2 || bub_active !== 1'b1 || bub_pop !== 1'b0) begin
         failures++;
         $display("FAIL low_spawn got Y=%0d a=%b p=%b want 2 a=1 p=0",
                  bub1Y, bub_active, bub_pop);
      end
      frame();
      frame();
      checks++;
      if (bub1Y !== 12'sd8 || bub_pop !== 1'b1) begin
         failures++;
         $display("FAIL low_clamp got Y=%0d p=%b want 8 p=1", bub1Y, bub_pop);
      end
      for (int i = 0; i < 8; i++) frame();
      checks++;
      if (bub_active !== 1'b0 || bub1Y !== -12'sd64) begin
         failures++;
         $display("FAIL low_park got Y=%0d a=%b want -64 a=0",
                  bub1Y, bub_active);
      end
   endtask

   task automatic test_simultaneous();
      subX = 12'sd100;
      subY = 12'sd300;
      @(negedge clk) begin
         launch = 1'b1;
         vsync  = 1'b1;
      end
      @(negedge clk) begin
         launch = 1'b0;
         vsync  = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (bub1X !== 12'sd116 || bub1Y !== 12'sd292 || bub_active !== 1'b1) begin
         failures++;
         $display("FAIL simul_spawn got %0d,%0d a=%b want 116,292 a=1",
                  bub1X, bub1Y, bub_active);
      end
      frame();
      checks++;
      if (bub1Y !== 12'sd292) begin
         failures++;
         $display("FAIL simul_tick1 got %0d want 292", bub1Y);
      end
      frame();
      checks++;
      if (bub1Y !== 12'sd290) begin
         failures++;
         $display("FAIL simul_tick2 got %0d want 290", bub1Y);
      end
   endtask

   task automatic test_wobble();
      logic signed [11:0] want [8];
      want = '{12'sd117, 12'sd118, 12'sd119, 12'sd118,
               12'sd117, 12'sd116, 12'sd115, 12'sd114};
      subX = 12'sd100;
      subY = 12'sd300;
      press();
      for (int i = 0; i < 8; i++) begin
         frame();
         frame();
`ifdef BUBBLE_WOBBLE_EN
         checks++;
         if (bub1X !== want[i]) begin
            failures++;
            $display("FAIL wobble_x%0d got %0d want %0d", i, bub1X, want[i]);
         end
`else
         checks++;
         if (bub1X !== 12'sd116) begin
            failures++;
            $display("FAIL const_x%0d got %0d want 116", i, bub1X);
         end
`endif
      end
      checks++;
      if (bub1Y !== 12'sd276) begin
         failures++;
         $display("FAIL wobble_y got %0d want 276", bub1Y);
      end
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_rise();
      test_async_reset();
      test_pop();
      test_low_spawn();
      test_simultaneous();
      test_async_reset();
      test_wobble();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
